// File: rtl/sync_down_counter_jk.sv
// -----------------------------------------------------------------------------
// sync_down_counter_jk
//
// Synchronous binary down counter built from JK-style toggle stages. Bit i
// toggles on an enabled edge when every lower bit is 0, so a borrow ripples
// up the chain inside one clock. Adds a parallel load, a combinational
// terminal-count/borrow output for cascading, and a registered zero flag.
//
// Build option:
//   SYNC_DOWN_COUNTER_AUTO_RELOAD_EN - when defined, an enabled edge at q == 0
//   (with load low) reloads load_value instead of wrapping to all-ones. The
//   counter then divides by (load_value + 1).
//
// Ports:
//   clk          in   rising-edge clock
//   cl           in   asynchronous active-high clear (q = 0, zero = 1)
//   count_enable in   decrement on the next rising edge
//   load         in   synchronous parallel load strobe (beats count_enable)
//   load_value   in   [WIDTH] value taken on load (and on auto-reload)
//   q            out  [WIDTH] current count
//   tc           out  count_enable & (q == 0); borrow-out to the next stage
//   zero         out  registered flag, high while q == 0
// -----------------------------------------------------------------------------
module sync_down_counter_jk #(
  parameter int WIDTH = 4  // legal range 2..16
) (
  input  logic             clk,
  input  logic             cl,
  input  logic             count_enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             zero_q, zero_d;

  // borrow[i] is the toggle condition for bit i: enabled and bits 0..i-1 all
  // zero. borrow[WIDTH] is therefore count_enable & (q == 0), i.e. tc.
  logic [WIDTH:0]   borrow;

  always_comb begin
    borrow[0] = count_enable;
    for (int i = 0; i < WIDTH; i++) begin
      borrow[i+1] = borrow[i] & ~q_q[i];
    end
  end

  assign tc = borrow[WIDTH];

  // NOTE: every output of this block gets a default first so that no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    q_d    = q_q;
    zero_d = zero_q;
    if (load) begin
      q_d    = load_value;
      zero_d = (load_value == '0);
    end else if (count_enable) begin
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
      if (tc) begin
        q_d    = load_value;
        zero_d = (load_value == '0);
      end else begin
        q_d    = q_q ^ borrow[WIDTH-1:0];
        zero_d = (q_q == WIDTH'(1));
      end
`else
      // Toggling each bit under its borrow is exactly q - 1 modulo 2^WIDTH.
      q_d    = q_q ^ borrow[WIDTH-1:0];
      zero_d = (q_q == WIDTH'(1));
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge cl) begin
    if (cl) begin
      q_q    <= '0;
      zero_q <= 1'b1;
    end else begin
      q_q    <= q_d;
      zero_q <= zero_d;
    end
  end

  assign q    = q_q;
  assign zero = zero_q;

endmodule
